// File: rtl/cpumc_arb.sv
// CPU memory-bus arbiter: stalls the RP2A03 via rdy, drains, then hands the
// cpumc bus to the HCI debug block or the PRG loader with a req/gnt handshake.
module cpumc_arb #(
  parameter int DRAIN_CYCLES = 4,
  parameter int BURST_LEN    = 256,
  parameter int CPU_MIN      = 8
) (
  input  logic        clk_in,
  input  logic        nrst_in,
  input  logic [15:0] cpu_a_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpu_d_in,
  input  logic        hci_req_in,
  input  logic [15:0] hci_a_in,
  input  logic        hci_r_nw_in,
  input  logic [7:0]  hci_d_in,
  input  logic        ldr_req_in,
  input  logic [15:0] ldr_a_in,
  input  logic        ldr_r_nw_in,
  input  logic [7:0]  ldr_d_in,
  output logic        rdy_out,
  output logic [15:0] a_out,
  output logic        r_nw_out,
  output logic [7:0]  d_out,
  output logic        hci_gnt_out,
  output logic        ldr_gnt_out,
  output logic [1:0]  owner_out
);

  typedef enum logic [2:0] {S_CPU, S_DRAIN, S_HCI, S_LDR, S_RET} state_t;

  localparam logic [1:0] OWN_CPU = 2'd0;
  localparam logic [1:0] OWN_HCI = 2'd1;
  localparam logic [1:0] OWN_LDR = 2'd2;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
  localparam logic [8:0] BURST_LAST = 9'(BURST_LEN - 1);
  localparam logic [7:0] WIN_INIT   = 8'(CPU_MIN);

  state_t      state, state_nxt;
  logic [3:0]  drain_cnt;
  logic [8:0]  burst_cnt;
  logic [7:0]  win_cnt;
  logic        sel_hci;

  // State, counters and the registered handshake outputs, which are all
  // derived from the next state so they line up with the bus mux below.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state       <= S_CPU;
      drain_cnt   <= '0;
      burst_cnt   <= '0;
      win_cnt     <= '0;
      sel_hci     <= 1'b0;
      rdy_out     <= 1'b1;
      hci_gnt_out <= 1'b0;
      ldr_gnt_out <= 1'b0;
      owner_out   <= OWN_CPU;
    end else begin
      // NOTE: non-blocking assignments for all state so every register
      // samples pre-edge values regardless of statement order.
      state       <= state_nxt;
      rdy_out     <= (state_nxt == S_CPU);
      hci_gnt_out <= (state_nxt == S_HCI);
      ldr_gnt_out <= (state_nxt == S_LDR);
      case (state_nxt)
        S_HCI:   owner_out <= OWN_HCI;
        S_LDR:   owner_out <= OWN_LDR;
        default: owner_out <= OWN_CPU;
      endcase

      case (state)
        S_CPU: begin
          if (state_nxt == S_DRAIN) begin
            sel_hci   <= hci_req_in;
            drain_cnt <= DRAIN_INIT;
          end else if (win_cnt != 8'd0) begin
            win_cnt <= win_cnt - 8'd1;
          end
        end
        S_DRAIN: begin
          burst_cnt <= '0;
          if (drain_cnt != 4'd0) drain_cnt <= drain_cnt - 4'd1;
        end
        S_LDR:   burst_cnt <= burst_cnt + 9'd1;
        S_RET:   win_cnt   <= WIN_INIT;
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt
    // unassigned, which would infer a latch.
    state_nxt = state;
    case (state)
      S_CPU:
        if (win_cnt == 8'd0 && (hci_req_in || ldr_req_in)) state_nxt = S_DRAIN;
      S_DRAIN:
        if (drain_cnt == 4'd0) begin
          if (sel_hci) state_nxt = hci_req_in ? S_HCI : S_RET;
          else         state_nxt = ldr_req_in ? S_LDR : S_RET;
        end
      S_HCI:
        if (!hci_req_in) state_nxt = S_RET;
      S_LDR:
        if (!ldr_req_in || burst_cnt == BURST_LAST) state_nxt = S_RET;
      S_RET:   state_nxt = S_CPU;
      default: state_nxt = S_CPU;
    endcase
  end

  // During DRAIN and RET the CPU address still drives the bus but writes are
  // suppressed, so a stalled CPU cycle can never corrupt memory.
  always_comb begin
    a_out    = cpu_a_in;
    r_nw_out = cpu_r_nw_in;
    d_out    = cpu_d_in;
    case (state)
      S_DRAIN, S_RET: r_nw_out = 1'b1;
      S_HCI: begin
        a_out    = hci_a_in;
        r_nw_out = hci_r_nw_in;
        d_out    = hci_d_in;
      end
      S_LDR: begin
        a_out    = ldr_a_in;
        r_nw_out = ldr_r_nw_in;
        d_out    = ldr_d_in;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpumc_arb.sv
// Directed bench for cpumc_arb with default parameters (4 / 256 / 8); all
// timing expectations are hand-computed from the arbitration rules.
module tb_cpumc_arb;

  localparam int DRAIN   = 4;
  localparam int BURST   = 256;
  localparam int WIN_RUN = 8 + 1;  // window cycles plus the arbitration cycle

  logic        clk_in = 1'b0;
  logic        nrst_in;
  logic [15:0] cpu_a_in = '0, hci_a_in = '0, ldr_a_in = '0;
  logic        cpu_r_nw_in = 1'b1, hci_r_nw_in = 1'b1, ldr_r_nw_in = 1'b1;
  logic [7:0]  cpu_d_in = '0, hci_d_in = '0, ldr_d_in = '0;
  logic        hci_req_in = 1'b0, ldr_req_in = 1'b0;
  logic        rdy_out, r_nw_out, hci_gnt_out, ldr_gnt_out;
  logic [15:0] a_out;
  logic [7:0]  d_out;
  logic [1:0]  owner_out;

  int total = 0;
  int bad   = 0;
  int n;

  cpumc_arb dut (
    .clk_in(clk_in), .nrst_in(nrst_in),
    .cpu_a_in(cpu_a_in), .cpu_r_nw_in(cpu_r_nw_in), .cpu_d_in(cpu_d_in),
    .hci_req_in(hci_req_in), .hci_a_in(hci_a_in), .hci_r_nw_in(hci_r_nw_in),
    .hci_d_in(hci_d_in),
    .ldr_req_in(ldr_req_in), .ldr_a_in(ldr_a_in), .ldr_r_nw_in(ldr_r_nw_in),
    .ldr_d_in(ldr_d_in),
    .rdy_out(rdy_out), .a_out(a_out), .r_nw_out(r_nw_out), .d_out(d_out),
    .hci_gnt_out(hci_gnt_out), .ldr_gnt_out(ldr_gnt_out), .owner_out(owner_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return rdy_out;
      1:       return hci_gnt_out;
      default: return ldr_gnt_out;
    endcase
  endfunction

  // Number of consecutive observations (starting now) with the signal high.
  task automatic run_len(input int which, input int limit, output int len);
    len = 0;
    while (pick(which) && len < limit) begin
      len++;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    nrst_in = 1'b1;
    #2 nrst_in = 1'b0;
    repeat (3) tick();
    check("rst_rdy", rdy_out, 1);
    check("rst_owner", owner_out, 0);
    check("rst_hci_gnt", hci_gnt_out, 0);
    check("rst_ldr_gnt", ldr_gnt_out, 0);
    nrst_in = 1'b1;

    // Idle CPU write passes straight through
    cpu_a_in = 16'h0012; cpu_r_nw_in = 1'b0; cpu_d_in = 8'h5a;
    tick();
    check("idle_rdy", rdy_out, 1);
    check("idle_owner", owner_out, 0);
    check("idle_a", a_out, 16'h0012);
    check("idle_rnw", r_nw_out, 0);
    check("idle_d", d_out, 8'h5a);
    tick();
    check("idle_rdy2", rdy_out, 1);

    // HCI request: drain, grant, release
    hci_a_in = 16'h8000; hci_r_nw_in = 1'b0; hci_d_in = 8'ha5; hci_req_in = 1'b1;
    tick();
    check("drain_rdy", rdy_out, 0);
    check("drain_rnw", r_nw_out, 1);
    check("drain_a", a_out, 16'h0012);
    check("drain_gnt", hci_gnt_out, 0);
    repeat (DRAIN - 1) tick();
    check("drain_last_gnt", hci_gnt_out, 0);
    tick();
    check("hci_gnt", hci_gnt_out, 1);
    check("hci_owner", owner_out, 1);
    check("hci_a", a_out, 16'h8000);
    check("hci_d", d_out, 8'ha5);
    check("hci_rnw", r_nw_out, 0);
    check("hci_rdy", rdy_out, 0);
    repeat (14) tick();
    check("hci_hold", hci_gnt_out, 1);
    hci_req_in = 1'b0;
    tick();
    check("hci_ret_gnt", hci_gnt_out, 0);
    check("hci_ret_rdy", rdy_out, 0);
    check("hci_ret_owner", owner_out, 0);
    check("hci_ret_rnw", r_nw_out, 1);
    tick();
    check("hci_back_rdy", rdy_out, 1);
    check("hci_back_rnw", r_nw_out, 0);

    // Simultaneous requests during the window: HCI first, loader after
    hci_req_in = 1'b1; ldr_req_in = 1'b1;
    ldr_a_in = 16'h4000; ldr_r_nw_in = 1'b0; ldr_d_in = 8'h3c;
    run_len(0, 50, n);
    check("win_len", n, WIN_RUN);
    repeat (DRAIN) tick();
    check("both_hci_gnt", hci_gnt_out, 1);
    check("both_ldr_gnt", ldr_gnt_out, 0);
    check("both_owner", owner_out, 1);
    repeat (5) tick();
    hci_req_in = 1'b0;
    tick();
    check("both_ret_ldr", ldr_gnt_out, 0);
    tick();
    check("both_back_rdy", rdy_out, 1);
    run_len(0, 50, n);
    check("win_len2", n, WIN_RUN);
    repeat (DRAIN) tick();
    check("ldr_gnt", ldr_gnt_out, 1);
    check("ldr_owner", owner_out, 2);
    check("ldr_a", a_out, 16'h4000);
    check("ldr_d", d_out, 8'h3c);
    check("ldr_rnw", r_nw_out, 0);

    // Loader holds req: forced release after BURST cycles, then re-grant
    run_len(2, 600, n);
    check("burst1_len", n, BURST);
    check("burst1_ret_rdy", rdy_out, 0);
    check("burst1_ret_own", owner_out, 0);
    tick();
    run_len(0, 50, n);
    check("burst_win", n, WIN_RUN);
    repeat (DRAIN) tick();
    check("regrant", ldr_gnt_out, 1);
    run_len(2, 600, n);
    check("burst2_len", n, BURST);
    tick();
    run_len(0, 50, n);
    check("burst_win2", n, WIN_RUN);
    repeat (DRAIN) tick();
    check("regrant2", ldr_gnt_out, 1);
    repeat (20) tick();
    ldr_req_in = 1'b0;
    tick();
    check("ldr_drop_gnt", ldr_gnt_out, 0);
    check("ldr_drop_rdy", rdy_out, 0);
    tick();
    check("ldr_drop_back", rdy_out, 1);
    check("ldr_drop_own", owner_out, 0);

    // Loader pulse dropped during drain: no grant
    repeat (10) tick();
    ldr_req_in = 1'b1;
    tick();
    check("pulse_rdy", rdy_out, 0);
    tick();
    ldr_req_in = 1'b0;
    repeat (2) tick();
    check("pulse_cnt0_gnt", ldr_gnt_out, 0);
    tick();
    check("pulse_ret_gnt", ldr_gnt_out, 0);
    check("pulse_ret_rdy", rdy_out, 0);
    tick();
    check("pulse_back_rdy", rdy_out, 1);

    // Asynchronous reset in the middle of an HCI grant
    repeat (10) tick();
    hci_req_in = 1'b1;
    tick();
    repeat (DRAIN) tick();
    check("pre_rst_gnt", hci_gnt_out, 1);
    #2 nrst_in = 1'b0;
    #1;
    check("async_rst_gnt", hci_gnt_out, 0);
    check("async_rst_owner", owner_out, 0);
    check("async_rst_rdy", rdy_out, 1);
    hci_req_in = 1'b0;
    tick();
    nrst_in = 1'b1;
    ldr_req_in = 1'b1;
    tick();
    check("post_rst_arb", rdy_out, 0);
    ldr_req_in = 1'b0;
    repeat (8) tick();
    check("post_rst_back", rdy_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpumc_arb.md
Name: cpumc_arb

Overview:
- Arbitrates the CPU memory bus (cpumc_a / cpumc_r_nw / cpumc_din) among three requesters:
  - the RP2A03 CPU, the default owner;
  - the HCI debug block;
  - a cartridge/PRG loader port.
- Replaces the current combinational hci_active mux in nes_top.
- Stalls the CPU through its rdy input, drains the in-flight access, grants the bus with a req/gnt handshake, then returns the bus to the CPU.
- Enforces a minimum CPU window after each return so the CPU cannot be starved.

Parameters:
- DRAIN_CYCLES, 4: cycles rdy is held low before any grant. Legal range 1..15.
- BURST_LEN, 256: maximum consecutive loader-grant cycles before a forced return. Legal range 1..511.
- CPU_MIN, 8: minimum CPU-owned cycles after a return before the next arbitration. Legal range 1..255.

Ports:
- clk_in  in  1  system clock (100 MHz)
- nrst_in  in  1  asynchronous active-low reset
- cpu_a_in  in  16  CPU address
- cpu_r_nw_in  in  1  CPU read/not-write
- cpu_d_in  in  8  CPU write data
- hci_req_in  in  1  HCI bus request, level
- hci_a_in  in  16  HCI address
- hci_r_nw_in  in  1  HCI read/not-write
- hci_d_in  in  8  HCI write data
- ldr_req_in  in  1  loader bus request, level
- ldr_a_in  in  16  loader address
- ldr_r_nw_in  in  1  loader read/not-write
- ldr_d_in  in  8  loader write data
- rdy_out  out  1  CPU ready; low stalls the CPU
- a_out  out  16  muxed cpumc address
- r_nw_out  out  1  muxed cpumc read/not-write
- d_out  out  8  muxed cpumc write data
- hci_gnt_out  out  1  HCI owns the bus
- ldr_gnt_out  out  1  loader owns the bus
- owner_out  out  2  current owner: 0 = CPU, 1 = HCI, 2 = loader

Behaviour:
- Reset values (asynchronous, while nrst_in = 0):
  - state CPU, rdy_out = 1, both grants 0, owner_out = 0;
  - window counter = 0, so arbitration is allowed immediately after reset.
- Register usage:
  - rdy_out, the grants and owner_out are registered.
  - a_out, r_nw_out and d_out are combinational from the registered state.
- States:
  - CPU:
    - rdy = 1; bus = cpu_* unchanged.
    - If the window counter is 0 and any request is high: latch sel (HCI if hci_req_in, else loader), load drain count with DRAIN_CYCLES-1, go to DRAIN.
    - rdy_out is low on the very next cycle.
    - Otherwise the window counter decrements toward 0.
  - DRAIN:
    - rdy = 0; bus = cpu_a_in / cpu_d_in with r_nw_out forced to 1, so no writes occur.
    - When the count reaches 0: if the latched requester's req is still high, go to HCI or LDR; otherwise go to RET.
  - HCI:
    - hci_gnt = 1, owner = 1, bus = hci_*; no length limit.
    - Go to RET the cycle after hci_req_in is sampled low.
  - LDR:
    - ldr_gnt = 1, owner = 2, bus = ldr_*; the burst counter increments each cycle.
    - Go to RET when ldr_req_in is sampled low or the burst counter reaches BURST_LEN-1 (forced release).
    - A forced-release loader must keep req high and is re-granted after the CPU window.
  - RET:
    - One cycle; grants 0, rdy = 0, bus = cpu_* with r_nw forced to 1.
    - Load window counter with CPU_MIN, go to CPU.
- Priority: HCI beats the loader when both are sampled high in the same CPU cycle.
  - HCI does not preempt an active loader grant. It waits for the loader to return, then wins the next arbitration.
- Grant timing:
  - A gnt rises exactly DRAIN_CYCLES+1 cycles after its req is first sampled high in CPU with window 0.
  - A requester drives its bus signals only while its gnt is high.
  - A requester must not drop and re-raise req within the same grant.
- Request drops:
  - A req dropped during DRAIN means no grant is issued; the block goes DRAIN -> RET.
  - A req is never granted without passing through DRAIN.
- Counter widths: drain 4 bits, burst 9 bits, window 8 bits, all unsigned; no wrap occurs within the legal parameter ranges.
- Reset mid-grant: grants drop and rdy_out rises asynchronously; the block re-enters CPU.

Test Plan:
- Idle after reset (nrst low 3 cycles, then high, no req):
  - rdy_out = 1, owner_out = 0, a_out == cpu_a_in;
  - cpu write (r_nw = 0, a = 0x0012, d = 0x5A) passes through unchanged.
- HCI request at cycle 10:
  - rdy_out low at cycle 11; r_nw_out = 1 during drain;
  - hci_gnt_out high at cycle 15, owner = 1;
  - hci_a 0x8000 appears on a_out.
  - hci_req low at cycle 30: gnt low at 31, rdy_out high at 32, then 8 CPU cycles with no re-arbitration.
- Simultaneous hci_req and ldr_req: HCI granted first.
  - After HCI releases plus the CPU_MIN window, the loader is granted (owner = 2).
- Loader holds req for 600 cycles with BURST_LEN = 256:
  - ldr_gnt high exactly 256 cycles, RET, 8 CPU cycles with rdy high, drain;
  - re-granted; repeats until req drops.
- ldr_req pulses for 2 cycles (drops during DRAIN): no ldr_gnt, DRAIN -> RET -> CPU, rdy restored.
- nrst_in asserted mid-HCI grant: hci_gnt_out and owner_out clear and rdy_out = 1 without waiting for a clock edge.
